bcd_stopwatch_ssd: RTL and testbench
====================================

# bcd_stopwatch_ssd

Parametrised BCD elapsed-time counter with a built-in seven-segment scan driver, replacing the ad-hoc timer and SSD logic in the game top level. The block counts ticks of a programmable period in N cascaded BCD digits, supports run/pause, synchronous clear, and wrap or saturate on overflow. It multiplexes the digits onto the board's common-anode display with optional leading-zero blanking. All logic runs on board_clk using clock enables; no derived clocks are used.

## Interface
- NUM_DIGITS, 4, number of BCD digits and anodes (1..8)
- TICK_DIV, 10_000_000, board_clk cycles per count (0.1 s at 100 MHz); must be ≥2
- SCAN_BITS, 18, log2 of board_clk cycles each digit is displayed
- SATURATE, 0, 0 = wrap all-9s to all-0s; 1 = hold at all-9s
- BLANK_LZ, 1, 1 = blank leading zero digits above DP_POS
- DP_POS, 1, index of the digit whose decimal point is lit; any value ≥ NUM_DIGITS means no DP

Ports:
- board_clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- run  in  1  level; count enable
- clear  in  1  synchronous; zeroes count, prescaler and overflow
- digits  out  4*NUM_DIGITS  packed BCD; digit 0 (least significant) in [3:0]
- tick_out  out  1  one-cycle pulse, high in the same cycle the new count first appears on digits
- overflow  out  1  sticky; set on the all-9s increment
- an  out  NUM_DIGITS  anodes, active-low
- seg  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low

## Operation
- Prescaler counts 0..TICK_DIV-1 while run=1 and holds while run=0, so a pause resumes mid-interval. When it is at TICK_DIV-1 with run=1, it returns to 0 and an increment occurs.
- Increment: digit i advances (9→0, otherwise +1) iff every digit below i equals 9. Digit 0 always advances.
- All digits 9 at increment:
  - SATURATE=0: all digits go to 0.
  - SATURATE=1: digits hold.
  - In both modes overflow←1 and tick_out still pulses.
- clear has priority over increment in the same cycle. It sets digits, prescaler and overflow to 0 and suppresses tick_out. clear does not affect the scan counter.
- Scan counter: free-running, width SCAN_BITS+⌈log2 NUM_DIGITS⌉. Its top bits give the scan index d, wrapping at NUM_DIGITS; this applies to non-power-of-two counts too.
  - an has exactly bit d low.
  - seg = decode(digit d), with Dp low iff d==DP_POS.
- Decode covers hex 0..F, using the team's standard abcdefg table. Non-BCD values cannot occur but still decode.
- Blanking (BLANK_LZ=1): digit d is blanked (seg=8'hFF, anode still driven) iff d>DP_POS and digits d..NUM_DIGITS-1 are all 0. Digits 0..DP_POS are never blanked. With DP_POS ≥ NUM_DIGITS, digit 0 is never blanked.

## Timing
- Reset values: digits=0, overflow=0, tick_out=0, prescaler=0, scan=0, an=all 1s, seg=8'hFF.
- digits, overflow and tick_out are registered and update on the same edge, one edge after the prescaler reaches TICK_DIV-1 with run=1.
- Period between increments is exactly TICK_DIV cycles with run held high.
- an/seg are registered: one cycle of latency after a scan index or digit change.
- run deasserting on the terminal-count cycle: the increment does not occur, and the prescaler holds at TICK_DIV-1.
- Async reset mid-count returns every register to its reset value immediately; the first increment after release occurs TICK_DIV cycles after the first run=1 edge.

## Structure
- Package ssd_pkg holds:
  - the 16-entry active-low segment constant table and a function seg_decode(4-bit)→7-bit
  - BCD width localparam (4)
  - the anode/segment polarity constants
- One sub-module, ssd_scan_mux, contains the scan counter, digit select, blanking and output registers. It is parametrised by NUM_DIGITS, SCAN_BITS, BLANK_LZ and DP_POS. The top level holds the prescaler, the BCD cascade and overflow.

## Test plan
Bench parameters: TICK_DIV=4, SCAN_BITS=2, NUM_DIGITS=4.
- Reset, run=1 for 40 cycles → digits=0x0010, tick_out every 4 cycles, first one 4 edges after run.
- Preload to 0x0999 by running, then one more tick → 0x1000. Preload 0x9999 + tick with SATURATE=0 → 0x0000, overflow=1. Same with SATURATE=1 → holds 0x9999, overflow=1.
- run drops for 7 cycles mid-interval (prescaler=2) → the next tick arrives 2 cycles after run returns; count is unchanged during the pause.
- clear and terminal count in the same cycle → digits=0, overflow=0, no tick_out. A later clear does not disturb the an sequence.
- digits=0x0005, BLANK_LZ=1, DP_POS=1 → an cycles 1110,1101,1011,0111, each for 4 cycles. seg values are 5 (Dp=1), 0 with Dp=0, FF, FF.
- With NUM_DIGITS=3, the scan index wraps 0,1,2,0 and an never drives an out-of-range anode.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared constants for the stopwatch and its seven-segment scan driver:
// BCD digit width, display polarity constants, the active-low segment
// table and the segment decode helper.
// Segment bit order is {Ca,Cb,Cc,Cd,Ce,Cf,Cg}; a 0 lights the segment.
package ssd_pkg;

    localparam int BCD_W = 4;

    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Hex 0..F glyphs, active-low abcdefg
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ssd_if.sv
// bcd_stopwatch_ssd_if
// Bundles the stopwatch control, count status and display pins.
//   run, clear         : control from the game logic (master drives)
//   digits             : packed BCD count, digit 0 in [3:0]
//   tick_out, overflow : count pulse and sticky overflow flag
//   an, seg            : active-low anodes and {Ca..Cg,Dp} segments
interface bcd_stopwatch_ssd_if
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                        run;
    logic                        clear;
    logic [BCD_W*NUM_DIGITS-1:0] digits;
    logic                        tick_out;
    logic                        overflow;
    logic [NUM_DIGITS-1:0]       an;
    logic [7:0]                  seg;

    modport master (
        output run, clear,
        input  digits, tick_out, overflow, an, seg
    );

    modport slave (
        input  run, clear,
        output digits, tick_out, overflow, an, seg
    );
endinterface

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux
// Time-multiplexes packed BCD digits onto a common-anode display.
//   board_clk, reset : clock and async active-high reset
//   digits_i         : packed BCD digits, digit 0 in [3:0]
//   an_o             : registered anodes, active-low, one low at a time
//   seg_o            : registered {Ca..Cg,Dp}, active-low
module ssd_scan_mux
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_BITS  = 18,
    parameter int BLANK_LZ   = 1,
    parameter int DP_POS     = 1
) (
    input  logic                        board_clk,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
    output logic [NUM_DIGITS-1:0]       an_o,
    output logic [7:0]                  seg_o
);

    // A single digit still needs a one-bit index field
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W = SCAN_BITS + IDX_W;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS * (1 << SCAN_BITS) - 1);
    // Digits above this index may be blanked; with no DP only digit 0 is kept
    localparam int BLANK_FROM = (DP_POS >= NUM_DIGITS) ? 0 : DP_POS;

    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx;
    logic [NUM_DIGITS-1:0] zeroFrom;
    logic [BCD_W-1:0]      curDigit;
    logic                  blank, dpOn;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic [7:0]            seg_d, seg_q;

    assign idx = scan_q[SCAN_W-1 -: IDX_W];

    // Wrap explicitly so non-power-of-two digit counts never select a missing anode
    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end

    // zeroFrom[i] is set when digits i..NUM_DIGITS-1 are all zero
    always_comb begin : zeroScan
        logic allZero;
        allZero  = 1'b1;
        zeroFrom = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allZero     = allZero & (digits_i[i*BCD_W +: BCD_W] == '0);
            zeroFrom[i] = allZero;
        end
    end

    always_comb begin
        curDigit = '0;
        blank    = 1'b0;
        dpOn     = 1'b0;
        an_d     = {NUM_DIGITS{AN_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                curDigit = digits_i[i*BCD_W +: BCD_W];
                blank    = (BLANK_LZ != 0) && (i > BLANK_FROM) && zeroFrom[i];
                dpOn     = (i == DP_POS);
                an_d[i]  = AN_ON;
            end
        end
        seg_d = blank ? SEG_BLANK : {seg_decode(curDigit), dpOn ? SEG_ON : SEG_OFF};
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            an_q   <= {NUM_DIGITS{AN_OFF}};
            seg_q  <= SEG_BLANK;
        end else begin
            scan_q <= scan_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: rtl/bcd_stopwatch_ssd.sv
// bcd_stopwatch_ssd
// BCD elapsed-time counter with prescaler, run/pause, synchronous clear,
// wrap or saturate on overflow, and a seven-segment scan driver.
//   board_clk : system clock
//   reset     : asynchronous, active-high
//   bus       : slave side of bcd_stopwatch_ssd_if (run, clear, digits,
//               tick_out, overflow, an, seg)
module bcd_stopwatch_ssd
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10_000_000,
    parameter int SCAN_BITS  = 18,
    parameter int SATURATE   = 0,
    parameter int BLANK_LZ   = 1,
    parameter int DP_POS     = 1
) (
    input  logic               board_clk,
    input  logic               reset,
    bcd_stopwatch_ssd_if.slave bus
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int DW = BCD_W * NUM_DIGITS;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [DW-1:0]    digits_q, digits_d, digitsInc;
    logic             overflow_q, overflow_d;
    logic             tick_q, tick_d;
    logic             allNines;

    // Ripple the carry up the digits; the final carry means every digit was 9
    always_comb begin : cascade
        logic carry;
        carry     = 1'b1;
        digitsInc = digits_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                digitsInc[i*BCD_W +: BCD_W] = (digits_q[i*BCD_W +: BCD_W] == BCD_W'(9))
                                            ? '0 : digits_q[i*BCD_W +: BCD_W] + BCD_W'(1);
            end
            carry = carry & (digits_q[i*BCD_W +: BCD_W] == BCD_W'(9));
        end
        allNines = carry;
    end

    // Clear beats everything; a paused prescaler holds so resume is mid-interval
    always_comb begin
        presc_d    = presc_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        tick_d     = 1'b0;
        if (bus.clear) begin
            presc_d    = '0;
            digits_d   = '0;
            overflow_d = 1'b0;
        end else if (bus.run) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (allNines) begin
                    overflow_d = 1'b1;
                end
                if (!(allNines && SATURATE != 0)) begin
                    digits_d = digitsInc;
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.digits   = digits_q;
    assign bus.tick_out = tick_q;
    assign bus.overflow = overflow_q;

    ssd_scan_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_BITS  (SCAN_BITS),
        .BLANK_LZ   (BLANK_LZ),
        .DP_POS     (DP_POS)
    ) u_scan (
        .board_clk (board_clk),
        .reset     (reset),
        .digits_i  (digits_q),
        .an_o      (bus.an),
        .seg_o     (bus.seg)
    );

endmodule

// File: tb/tb_bcd_stopwatch_ssd.sv
// tb_bcd_stopwatch_ssd
// Drives three stopwatch instances (4 digits wrapping, 4 digits saturating,
// 3 digits wrapping) from one run/clear stream and compares them against an
// integer-count reference model, a table of phase vectors and hand-written
// display sequences.
module tb_bcd_stopwatch_ssd;

    localparam int TICK  = 4;
    localparam int SCANB = 2;
    localparam int DP    = 1;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic runSig   = 1'b0;
    logic clearSig = 1'b0;

    always #5 clock = ~clock;

    bcd_stopwatch_ssd_if #(.NUM_DIGITS(4)) busWrap ();
    bcd_stopwatch_ssd_if #(.NUM_DIGITS(4)) busSat ();
    bcd_stopwatch_ssd_if #(.NUM_DIGITS(3)) bus3 ();

    assign busWrap.run   = runSig;
    assign busWrap.clear = clearSig;
    assign busSat.run    = runSig;
    assign busSat.clear  = clearSig;
    assign bus3.run      = runSig;
    assign bus3.clear    = clearSig;

    bcd_stopwatch_ssd #(.NUM_DIGITS(4), .TICK_DIV(TICK), .SCAN_BITS(SCANB),
                        .SATURATE(0), .BLANK_LZ(1), .DP_POS(DP))
        dutWrap (.board_clk(clock), .reset(reset), .bus(busWrap));

    bcd_stopwatch_ssd #(.NUM_DIGITS(4), .TICK_DIV(TICK), .SCAN_BITS(SCANB),
                        .SATURATE(1), .BLANK_LZ(1), .DP_POS(DP))
        dutSat (.board_clk(clock), .reset(reset), .bus(busSat));

    bcd_stopwatch_ssd #(.NUM_DIGITS(3), .TICK_DIV(TICK), .SCAN_BITS(SCANB),
                        .SATURATE(0), .BLANK_LZ(1), .DP_POS(DP))
        dut3 (.board_clk(clock), .reset(reset), .bus(bus3));

    int checks = 0;
    int passes = 0;

    // Reference model: elapsed count as a plain integer per instance
    const int ND  [3] = '{4, 4, 3};
    const int SAT [3] = '{0, 1, 0};
    int mCount [3];
    int mPresc [3];
    int mScan  [3];
    int mOvf   [3];
    int mTick  [3];
    int mAn    [3];
    int mSeg   [3];

    // Active-low abcdefg glyphs for hex 0..F
    const int segTab [16] = '{'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F,
                              'h00, 'h04, 'h08, 'h60, 'h31, 'h42, 'h30, 'h38};

    typedef struct {
        int run;
        int clear;
        int cycles;
        int expWrap;
        int expSat;
        int expOvfWrap;
        int expOvfSat;
        int expTick;
    } vector_t;

    vector_t vectors [18];

    const int anSeq  [4] = '{'b1110, 'b1101, 'b1011, 'b0111};
    const int segSeq [4] = '{'h49, 'h02, 'hFF, 'hFF};

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic int digitOf(input int v, input int i);
        return (v / pow10(i)) % 10;
    endfunction

    function automatic int bcdOf(input int v, input int nd);
        int r = 0;
        for (int i = 0; i < nd; i++) r = r | (digitOf(v, i) << (4 * i));
        return r;
    endfunction

    task automatic checkOutput(input string name, input int unsigned actual,
                               input int unsigned expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mCount[k] = 0;
            mPresc[k] = 0;
            mScan[k]  = 0;
            mOvf[k]   = 0;
            mTick[k]  = 0;
            mAn[k]    = (1 << ND[k]) - 1;
            mSeg[k]   = 'hFF;
        end
    endtask

    task automatic modelStep(input int r, input int c);
        int idx;
        int blank;
        for (int k = 0; k < 3; k++) begin
            // Display registers reflect the state before this edge
            idx     = mScan[k] / (1 << SCANB);
            mAn[k]  = ((1 << ND[k]) - 1) ^ (1 << idx);
            blank   = (idx > DP) && (mCount[k] < pow10(idx));
            mSeg[k] = blank ? 'hFF : ((segTab[digitOf(mCount[k], idx)] << 1) | ((idx == DP) ? 0 : 1));
            mScan[k] = (mScan[k] + 1) % (ND[k] * (1 << SCANB));
            mTick[k] = 0;
            if (c != 0) begin
                mCount[k] = 0;
                mPresc[k] = 0;
                mOvf[k]   = 0;
            end else if (r != 0) begin
                if (mPresc[k] == TICK - 1) begin
                    mPresc[k] = 0;
                    mTick[k]  = 1;
                    if (mCount[k] == pow10(ND[k]) - 1) begin
                        mOvf[k] = 1;
                        if (SAT[k] == 0) mCount[k] = 0;
                    end else begin
                        mCount[k] = mCount[k] + 1;
                    end
                end else begin
                    mPresc[k] = mPresc[k] + 1;
                end
            end
        end
    endtask

    task automatic checkModel();
        checkOutput("wrap digits", busWrap.digits,   bcdOf(mCount[0], 4));
        checkOutput("wrap tick",   busWrap.tick_out, mTick[0]);
        checkOutput("wrap ovf",    busWrap.overflow, mOvf[0]);
        checkOutput("wrap an",     busWrap.an,       mAn[0]);
        checkOutput("wrap seg",    busWrap.seg,      mSeg[0]);
        checkOutput("sat digits",  busSat.digits,    bcdOf(mCount[1], 4));
        checkOutput("sat tick",    busSat.tick_out,  mTick[1]);
        checkOutput("sat ovf",     busSat.overflow,  mOvf[1]);
        checkOutput("sat an",      busSat.an,        mAn[1]);
        checkOutput("sat seg",     busSat.seg,       mSeg[1]);
        checkOutput("d3 digits",   bus3.digits,      bcdOf(mCount[2], 3));
        checkOutput("d3 tick",     bus3.tick_out,    mTick[2]);
        checkOutput("d3 ovf",      bus3.overflow,    mOvf[2]);
        checkOutput("d3 an",       bus3.an,          mAn[2]);
        checkOutput("d3 seg",      bus3.seg,         mSeg[2]);
    endtask

    // Called at posedge+1; returns at the next posedge+1 after checking
    task automatic applyStimulus(input int r, input int c);
        runSig   = (r != 0);
        clearSig = (c != 0);
        @(posedge clock);
        modelStep(r, c);
        #1;
        checkModel();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " digits"}, busWrap.digits,   0);
        checkOutput({tag, " ovf"},    busWrap.overflow, 0);
        checkOutput({tag, " tick"},   busWrap.tick_out, 0);
        checkOutput({tag, " an"},     busWrap.an,       'hF);
        checkOutput({tag, " seg"},    busWrap.seg,      'hFF);
        checkOutput({tag, " an3"},    bus3.an,          'h7);
    endtask

    initial begin
        int found;
        int prevAn;

        vectors[0]  = '{1, 0, 40,    'h0010, 'h0010, 0, 0, 1};
        vectors[1]  = '{1, 0, 3956,  'h0999, 'h0999, 0, 0, 1};
        vectors[2]  = '{1, 0, 4,     'h1000, 'h1000, 0, 0, 1};
        vectors[3]  = '{1, 0, 35996, 'h9999, 'h9999, 0, 0, 1};
        vectors[4]  = '{1, 0, 4,     'h0000, 'h9999, 1, 1, 1};
        vectors[5]  = '{1, 0, 3,     'h0000, 'h9999, 1, 1, 0};
        vectors[6]  = '{1, 1, 1,     'h0000, 'h0000, 0, 0, 0};
        vectors[7]  = '{1, 0, 4,     'h0001, 'h0001, 0, 0, 1};
        vectors[8]  = '{1, 0, 2,     'h0001, 'h0001, 0, 0, 0};
        vectors[9]  = '{0, 0, 7,     'h0001, 'h0001, 0, 0, 0};
        vectors[10] = '{1, 0, 1,     'h0001, 'h0001, 0, 0, 0};
        vectors[11] = '{1, 0, 1,     'h0002, 'h0002, 0, 0, 1};
        vectors[12] = '{1, 0, 3,     'h0002, 'h0002, 0, 0, 0};
        vectors[13] = '{0, 0, 3,     'h0002, 'h0002, 0, 0, 0};
        vectors[14] = '{1, 0, 1,     'h0003, 'h0003, 0, 0, 1};
        vectors[15] = '{0, 1, 1,     'h0000, 'h0000, 0, 0, 0};
        vectors[16] = '{1, 0, 20,    'h0005, 'h0005, 0, 0, 1};
        vectors[17] = '{0, 0, 1,     'h0005, 'h0005, 0, 0, 0};

        $display("[TB] start");
        repeat (3) @(posedge clock);
        #1;
        modelReset();
        checkResetValues("reset");
        reset = 1'b0;

        // Phase table: each row runs for a number of cycles, then the end state is checked
        for (int v = 0; v < 18; v++) begin
            for (int n = 0; n < vectors[v].cycles; n++)
                applyStimulus(vectors[v].run, vectors[v].clear);
            checkOutput($sformatf("vec%0d wrap digits", v), busWrap.digits,   vectors[v].expWrap);
            checkOutput($sformatf("vec%0d sat digits", v),  busSat.digits,    vectors[v].expSat);
            checkOutput($sformatf("vec%0d wrap ovf", v),    busWrap.overflow, vectors[v].expOvfWrap);
            checkOutput($sformatf("vec%0d sat ovf", v),     busSat.overflow,  vectors[v].expOvfSat);
            checkOutput($sformatf("vec%0d tick", v),        busWrap.tick_out, vectors[v].expTick);
        end

        // Align to the first cycle digit 0 is shown, then walk one full scan
        found  = 0;
        prevAn = busWrap.an;
        for (int n = 0; n < 20 && found == 0; n++) begin
            applyStimulus(0, 0);
            if (busWrap.an == 4'b1110 && prevAn != 'b1110) found = 1;
            prevAn = busWrap.an;
        end
        checkOutput("scan align", found, 1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) applyStimulus(0, 0);
            checkOutput($sformatf("blank an k%0d", k),  busWrap.an,  anSeq[k / 4]);
            checkOutput($sformatf("blank seg k%0d", k), busWrap.seg, segSeq[k / 4]);
        end

        // A clear mid-scan must not shift the anode sequence
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, (k == 5) ? 1 : 0);
            checkOutput($sformatf("clear an k%0d", k), busWrap.an, anSeq[k / 4]);
        end

        // Three-digit instance only ever drives one of its three anodes
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1, 0);
            checkOutput("an3 single", $countones(~bus3.an), 1);
        end

        // Asynchronous reset mid-count takes effect before any edge
        for (int k = 0; k < 50; k++) applyStimulus(1, 0);
        reset = 1'b1;
        #1;
        checkResetValues("async reset");
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0);
            checkOutput($sformatf("post reset tick e%0d", i), busWrap.tick_out, (i == 4) ? 1 : 0);
        end

        // Random run/clear traffic against the model
        for (int k = 0; k < 3000; k++)
            applyStimulus(($urandom_range(0, 3) != 0) ? 1 : 0,
                          ($urandom_range(0, 49) == 0) ? 1 : 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
